// File: rtl/axi_w_route_pkg.sv
// Shared types and helpers for the AXI W-channel routing FIFO.
// Optional build macro: AXI_W_ROUTE_FALL_THROUGH_EN (see axi_w_route_fifo).
package axi_w_route_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int SLV_IDX_W     = 4;
    localparam int ID_W          = 4;

    // One routing entry: which slave owns the burst and the AXI ID it carries.
    typedef struct packed {
        logic [SLV_IDX_W-1:0] slv_idx;
        logic [ID_W-1:0]      id;
    } route_entry_t;

    localparam int ROUTE_ENTRY_W = $bits(route_entry_t);

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axi_w_route_fifo_ctrl.sv
// Pointer, occupancy and error-flag control for axi_w_route_fifo.
// Optional build macro: AXI_W_ROUTE_FALL_THROUGH_EN (empty + push + pop
// bypasses storage and is not an underflow).
import axi_w_route_pkg::*;

module axi_w_route_fifo_ctrl #(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1,
    parameter int PTR_W     = ptr_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic                 pop_i,
    output logic                 wr_en_o,
    output logic [PTR_W-1:0]     wptr_o,
    output logic [PTR_W-1:0]     rptr_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 push_ok, pop_ok;

    // Flags come only from the registered count, never from this cycle's inputs.
    assign full_o      = (count_q == CNT_WIDTH'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign wptr_o      = wptr_q;
    assign rptr_o      = rptr_q;
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

    // Accept/reject decisions and next-state for pointers, count and sticky errors.
    always_comb begin
        // A pop frees a slot in the same edge, so a full FIFO still takes a push with pop.
        push_ok = push_i && (!full_o || pop_i);
        pop_ok  = pop_i && !empty_o;
        ovf_d   = ovf_q || (push_i && full_o && !pop_i);
        unf_d   = unf_q || (pop_i && empty_o);
`ifdef AXI_W_ROUTE_FALL_THROUGH_EN
        // Entry goes straight from push_data_i to the consumer: no write, no underflow.
        if (empty_o && push_i && pop_i) begin
            push_ok = 1'b0;
            unf_d   = unf_q;
        end
`endif
        wptr_d  = push_ok ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop_ok  ? rptr_q + PTR_W'(1) : rptr_q;
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
        // Reset wins, so never let a same-cycle push touch storage.
        wr_en_o = push_ok && !rst;
    end

    // State registers with synchronous reset taking priority over push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

endmodule

// File: rtl/axi_w_route_fifo.sv
// Routing-info FIFO for the AXI node: AW handshake pushes (slave index, ID),
// W last-beat handshake pops; the head steers the W mux.
// Optional build macro: AXI_W_ROUTE_FALL_THROUGH_EN - when empty, a push is
// visible on the head in the same cycle so single-beat bursts can complete
// with AW and W-last in one cycle.
import axi_w_route_pkg::*;

module axi_w_route_fifo #(
    parameter int DATA_WIDTH = ROUTE_ENTRY_W,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic                  head_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic                  wr_en;
    logic [PTR_W-1:0]      wptr, rptr;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    axi_w_route_fifo_ctrl #(
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH),
        .PTR_W     (PTR_W)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_i),
        .pop_i       (pop_i),
        .wr_en_o     (wr_en),
        .wptr_o      (wptr),
        .rptr_o      (rptr),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr] <= push_data_i;
    end

    // Head selection: oldest entry from registered state, zero when empty.
    always_comb begin
        head_valid_o = !empty_o;
        head_data_o  = '0;
        if (!empty_o) head_data_o = mem_q[rptr];
`ifdef AXI_W_ROUTE_FALL_THROUGH_EN
        if (empty_o && push_i) begin
            head_valid_o = 1'b1;
            head_data_o  = push_data_i;
        end
`endif
    end

endmodule
